// File: rtl/gcm_instance_sequencer.sv
// Purpose : feeds one AES-GCM instance at a time into the front of the encryption
//           pipeline as a registered beat stream: INIT, AAD blocks, PT blocks, LEN.
//           A missing data block turns into a phase-0 bubble without advancing any count.
// Ports   : descriptor in (i_desc_*, valid/ready), data blocks in (i_data*, valid/ready),
//           beat outputs (o_phase, o_new_instance, o_counter, o_aad, o_plain_text, o_done),
//           held instance context (o_iv, o_key_schedule, o_instance_size) and o_busy.
module gcm_instance_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_desc_valid,
  output logic             o_desc_ready,
  input  logic [0:95]      i_desc_iv,
  input  logic [0:1407]    i_desc_key_schedule,
  input  logic [CNT_W-1:0] i_desc_aad_blocks,
  input  logic [CNT_W-1:0] i_desc_pt_blocks,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [0:127]     i_data,
  output logic [0:2]       o_phase,
  output logic             o_new_instance,
  output logic [0:95]      o_iv,
  output logic [0:1407]    o_key_schedule,
  output logic [0:127]     o_counter,
  output logic [0:127]     o_aad,
  output logic [0:127]     o_plain_text,
  output logic [0:127]     o_instance_size,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_AAD, S_PT, S_LEN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] aad_q, aad_d;
  logic [CNT_W-1:0] pt_q, pt_d;
  logic [CNT_W-1:0] blk_q, blk_d;      // blocks accepted so far in the current phase
  logic [0:95]      iv_q, iv_d;
  logic [0:1407]    key_q, key_d;
  logic [0:127]     size_q, size_d;
  logic [0:2]       phase_q, phase_d;
  logic             new_q, new_d;
  logic [0:127]     ctr_q, ctr_d;
  logic [0:127]     aad_dat_q, aad_dat_d;
  logic [0:127]     pt_dat_q, pt_dat_d;
  logic             done_q, done_d;

  // One bit wider than the count so the "last block" test cannot overflow at 2^CNT_W-1.
  logic [CNT_W:0]   blk_inc;
  assign blk_inc = {1'b0, blk_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    aad_d     = aad_q;
    pt_d      = pt_q;
    blk_d     = blk_q;
    iv_d      = iv_q;
    key_d     = key_q;
    size_d    = size_q;
    phase_d   = 3'd0;
    new_d     = 1'b0;
    ctr_d     = '0;
    aad_dat_d = '0;
    pt_dat_d  = '0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_desc_valid) begin
          iv_d    = i_desc_iv;
          key_d   = i_desc_key_schedule;
          aad_d   = i_desc_aad_blocks;
          pt_d    = i_desc_pt_blocks;
          blk_d   = '0;
          // Bit lengths: block count times 128.
          size_d  = {64'(i_desc_aad_blocks) << 7, 64'(i_desc_pt_blocks) << 7};
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        phase_d = 3'd1;
        new_d   = 1'b1;
        ctr_d   = {iv_q, 32'd1};
        if (aad_q != '0)     state_d = S_AAD;
        else if (pt_q != '0) state_d = S_PT;
        else                 state_d = S_LEN;
      end
      S_AAD: begin
        if (i_data_valid) begin
          phase_d   = 3'd2;
          aad_dat_d = i_data;
          if (blk_inc == {1'b0, aad_q}) begin
            blk_d   = '0;
            state_d = (pt_q != '0) ? S_PT : S_LEN;
          end else begin
            blk_d   = blk_inc[CNT_W-1:0];
          end
        end
      end
      S_PT: begin
        if (i_data_valid) begin
          phase_d  = 3'd3;
          pt_dat_d = i_data;
          // PT counters start at 2 (1 is J0); 32-bit add wraps naturally.
          ctr_d    = {iv_q, 32'(blk_q) + 32'd2};
          if (blk_inc == {1'b0, pt_q}) begin
            blk_d   = '0;
            state_d = S_LEN;
          end else begin
            blk_d   = blk_inc[CNT_W-1:0];
          end
        end
      end
      S_LEN: begin
        phase_d = 3'd4;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      aad_q     <= '0;
      pt_q      <= '0;
      blk_q     <= '0;
      iv_q      <= '0;
      key_q     <= '0;
      size_q    <= '0;
      phase_q   <= '0;
      new_q     <= 1'b0;
      ctr_q     <= '0;
      aad_dat_q <= '0;
      pt_dat_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aad_q     <= aad_d;
      pt_q      <= pt_d;
      blk_q     <= blk_d;
      iv_q      <= iv_d;
      key_q     <= key_d;
      size_q    <= size_d;
      phase_q   <= phase_d;
      new_q     <= new_d;
      ctr_q     <= ctr_d;
      aad_dat_q <= aad_dat_d;
      pt_dat_q  <= pt_dat_d;
      done_q    <= done_d;
    end
  end

  // Handshake and busy are decoded from state, gated off while reset is held.
  assign o_desc_ready    = ~rst & (state_q == S_IDLE);
  assign o_data_ready    = ~rst & ((state_q == S_AAD) | (state_q == S_PT));
  assign o_busy          = ~rst & (state_q != S_IDLE);

  assign o_phase         = phase_q;
  assign o_new_instance  = new_q;
  assign o_iv            = iv_q;
  assign o_key_schedule  = key_q;
  assign o_counter       = ctr_q;
  assign o_aad           = aad_dat_q;
  assign o_plain_text    = pt_dat_q;
  assign o_instance_size = size_q;
  assign o_done          = done_q;

endmodule
